// File: rtl/mm_pkg.sv
// Shared matrix-multiply helpers and default sizes used by vectorSum,
// dot_row_collector and the matrix top.
package mm_pkg;

  localparam int DIM_DEF = 2;
  localparam int W_U_DEF = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Sum of DIM products of width W_u needs clog2(DIM) extra carry bits.
  function automatic int res_width(input int w_u, input int dim);
    return w_u + clog2(dim);
  endfunction

endpackage

// File: rtl/dot_row_collector_if.sv
// Sum-in / row-out handshake bundle of the dot-product row collector.
interface dot_row_collector_if #(
  parameter int DIM       = 2,
  parameter int RES_WIDTH = 33
);
  logic [RES_WIDTH-1:0]     sum_in;
  logic                     sum_valid;
  logic                     sum_ready;
  logic [DIM*RES_WIDTH-1:0] row_out;
  logic                     row_valid;
  logic                     row_ready;

  modport slave (
    input  sum_in, sum_valid, row_ready,
    output sum_ready, row_out, row_valid
  );

  modport master (
    output sum_in, sum_valid, row_ready,
    input  sum_ready, row_out, row_valid
  );
endinterface

// File: rtl/dot_row_collector_sync_fifo.sv
// Synchronous FIFO with occupancy count; read data reads zero while empty.
module sync_fifo
  import mm_pkg::*;
#(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rd_data,
  output logic [clog2(DEPTH):0]   count
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Gate the storage so nothing stale or uninitialised leaks out when empty.
  assign rd_data = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dot_row_collector.sv
// Packs DIM consecutive dot-product sums into a row and buffers rows in a FIFO.
// Optional sticky overrun flag drop_err under DOT_ROW_COLLECTOR_DROP_FLAG_EN.
module dot_row_collector
  import mm_pkg::*;
#(
  parameter  int DIM        = DIM_DEF,
  parameter  int W_u        = W_U_DEF,
  parameter  int FIFO_DEPTH = 4,
  localparam int RES_WIDTH  = res_width(W_u, DIM),
  localparam int CW         = (DIM > 1) ? clog2(DIM) : 1
) (
  input  logic                Clock,
  input  logic                Resetn,
  dot_row_collector_if.slave  bus,
  output logic [15:0]         row_count,
  output logic [CW-1:0]       col_idx
`ifdef DOT_ROW_COLLECTOR_DROP_FLAG_EN
  ,
  output logic                drop_err
`endif
);
  localparam int FCW = clog2(FIFO_DEPTH) + 1;

  logic [DIM-1:0][RES_WIDTH-1:0] pack_q, row_d;
  logic [FCW-1:0]                fifo_count;
  logic                          last_col, accept, push, pop;

  assign last_col      = (col_idx == CW'(DIM - 1));
  // Ready depends only on registered state; a pop in the same cycle cannot
  // make room for the closing element.
  assign bus.sum_ready = !last_col || (fifo_count < FCW'(FIFO_DEPTH));
  assign accept        = bus.sum_valid && bus.sum_ready;
  assign push          = accept && last_col;
  assign bus.row_valid = (fifo_count != '0);
  assign pop           = bus.row_valid && bus.row_ready;

  // Per-slice merge: the slice at col_idx takes the incoming sum.
  for (genvar k = 0; k < DIM; k++) begin : g_slice
    assign row_d[k] = (col_idx == CW'(k)) ? bus.sum_in : pack_q[k];
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pack_q    <= '0;
      col_idx   <= '0;
      row_count <= '0;
    end else begin
      if (accept) begin
        pack_q  <= row_d;
        col_idx <= last_col ? '0 : col_idx + CW'(1);
      end
      if (pop) row_count <= row_count + 16'd1;
    end
  end

`ifdef DOT_ROW_COLLECTOR_DROP_FLAG_EN
  always_ff @(posedge Clock) begin
    if (!Resetn)                              drop_err <= 1'b0;
    else if (bus.sum_valid && !bus.sum_ready) drop_err <= 1'b1;
  end
`endif

  sync_fifo #(
    .WIDTH (DIM*RES_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .push    (push),
    .wr_data (row_d),
    .pop     (pop),
    .rd_data (bus.row_out),
    .count   (fifo_count)
  );

endmodule
